oled_pixel_streamer: RTL and testbench

Display-side master for the 96x64 OLED pixel interface. Sweeps pixel_index across the frame and captures the 16-bit RGB565 colour that a pixel renderer returns. Serialises each frame as a window-set command header followed by the pixel stream over a 4-wire SPI-style link (cs_n, sclk, sdin, dc). Sits between the renderer/compositor chain and the OLED pins; panel power-up initialisation is handled elsewhere.

---
 rtl/oled_pixel_streamer.sv | 228 ++++++++++++++++++++++
 tb/tb_oled_pixel_streamer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/oled_pixel_streamer.sv
// oled_pixel_streamer: frame sweeper and 4-wire serialiser for a 96x64 RGB565 OLED.
// Each frame is a 6-byte window command header (dc=0) followed by WIDTH*HEIGHT
// 16-bit pixels (dc=1), MSB first, with sclk idling high and data launched on
// its falling edge. The next pixel is prefetched while the current one shifts.
// Optional build macro: STREAMER_TEST_PATTERN_EN replaces the renderer data
// with a white border / black interior test frame.
module oled_pixel_streamer #(
  parameter int unsigned WIDTH     = 96,
  parameter int unsigned HEIGHT    = 64,
  parameter int unsigned CLK_DIV   = 2,   // clk25 cycles per sclk half-period, >= 1
  parameter int unsigned FRAME_GAP = 16   // cs_n-high cycles between frames, >= 1
) (
  input  logic        clk25,
  input  logic        rst_n,
  input  logic        enable,
  output logic [12:0] pixel_index,
  input  logic [15:0] pixel_data,
  output logic        frame_begin,
  output logic        busy,
  output logic        cs_n,
  output logic        sclk,
  output logic        sdin,
  output logic        dc
);

  localparam int unsigned PIX_W  = 13;
  localparam int unsigned NPIX   = WIDTH * HEIGHT;
  localparam int unsigned DIV_W  = $clog2(CLK_DIV + 1);
  localparam int unsigned GAP_W  = $clog2(FRAME_GAP + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_PIX  = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [PIX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [15:0]      word_q, word_d;
  logic [15:0]      hold_q, hold_d;
  logic [2:0]       fetch_q, fetch_d;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             sdin_q, sdin_d;
  logic             dc_q, dc_d;
  logic             fb_q, fb_d;
  logic             busy_q, busy_d;

  logic [15:0]      cap_word_c;
  logic [15:0]      cur_word_c;
  logic [7:0]       first_byte_c;
  logic [7:0]       next_byte_c;
  logic [PIX_W-1:0] pix_start_c;
  logic [PIX_W-1:0] idx_next_c;

  // Window-set header: column range 0..WIDTH-1, row range 0..HEIGHT-1.
  function automatic logic [7:0] hdr_byte(input logic [2:0] b);
    case (b)
      3'd0:    return 8'h15;
      3'd1:    return 8'h00;
      3'd2:    return 8'(WIDTH - 1);
      3'd3:    return 8'h75;
      3'd4:    return 8'h00;
      3'd5:    return 8'(HEIGHT - 1);
      default: return 8'h00;
    endcase
  endfunction

`ifdef STREAMER_TEST_PATTERN_EN
  // Border test pattern computed from the index being fetched.
  logic [PIX_W-1:0] x_c;
  logic             unused_pixel_data_c;
  assign x_c                 = idx_q % PIX_W'(WIDTH);
  assign unused_pixel_data_c = ^pixel_data;
  assign cap_word_c = (idx_q < PIX_W'(WIDTH) || idx_q >= PIX_W'(NPIX - WIDTH) ||
                       x_c == '0 || x_c == PIX_W'(WIDTH - 1)) ? 16'hFFFF : 16'h0000;
`else
  assign cap_word_c = pixel_data;
`endif

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    pix_d   = pix_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    word_d  = word_q;
    hold_d  = fetch_q[2] ? cap_word_c : hold_q;
    fetch_d = {fetch_q[1:0], 1'b0};
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    sdin_d  = sdin_q;
    dc_d    = dc_q;
    fb_d    = 1'b0;
    busy_d  = busy_q;

    first_byte_c = hdr_byte(3'd0);
    next_byte_c  = hdr_byte(byte_q + 3'd1);
    cur_word_c   = (state_q == S_CMD) ? {8'h00, hdr_byte(byte_q)} : word_q;
    pix_start_c  = (state_q == S_CMD) ? '0 : pix_q + PIX_W'(1);
    idx_next_c   = pix_start_c + PIX_W'(1);

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (enable) begin
          state_d    = S_CMD;
          fb_d       = 1'b1;
          busy_d     = 1'b1;
          cs_n_d     = 1'b0;
          sclk_d     = 1'b0;
          dc_d       = 1'b0;
          sdin_d     = first_byte_c[7];
          div_d      = '0;
          bit_d      = 4'd7;
          byte_d     = 3'd0;
          pix_d      = '0;
          fetch_d[0] = 1'b1;
        end
      end
      S_CMD, S_PIX: begin
        if (div_q != DIV_W'(CLK_DIV - 1)) begin
          div_d = div_q + DIV_W'(1);
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          div_d  = '0;
        end else begin
          div_d = '0;
          if (bit_q != 4'd0) begin
            bit_d  = bit_q - 4'd1;
            sclk_d = 1'b0;
            sdin_d = cur_word_c[bit_q - 4'd1];
          end else if (state_q == S_CMD && byte_q != 3'd5) begin
            byte_d = byte_q + 3'd1;
            bit_d  = 4'd7;
            sclk_d = 1'b0;
            sdin_d = next_byte_c[7];
          end else if (state_q == S_CMD || pix_q != PIX_W'(NPIX - 1)) begin
            // Word boundary: load prefetched pixel and launch the next fetch.
            state_d    = S_PIX;
            word_d     = hold_q;
            sdin_d     = hold_q[15];
            dc_d       = 1'b1;
            bit_d      = 4'd15;
            sclk_d     = 1'b0;
            pix_d      = pix_start_c;
            idx_d      = (idx_next_c == PIX_W'(NPIX)) ? '0 : idx_next_c;
            fetch_d[0] = 1'b1;
          end else begin
            state_d = S_GAP;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b1;
            sdin_d  = 1'b0;
            dc_d    = 1'b0;
            busy_d  = 1'b0;
            gap_d   = '0;
            bit_d   = '0;
            byte_d  = '0;
            pix_d   = '0;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(FRAME_GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      pix_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      hold_q  <= '0;
      fetch_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      sdin_q  <= 1'b0;
      dc_q    <= 1'b0;
      fb_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      pix_q   <= pix_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      hold_q  <= hold_d;
      fetch_q <= fetch_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      sdin_q  <= sdin_d;
      dc_q    <= dc_d;
      fb_q    <= fb_d;
      busy_q  <= busy_d;
    end
  end

  assign pixel_index = idx_q;
  assign frame_begin = fb_q;
  assign busy        = busy_q;
  assign cs_n        = cs_n_q;
  assign sclk        = sclk_q;
  assign sdin        = sdin_q;
  assign dc          = dc_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Directed bench for oled_pixel_streamer on a reduced 12x6 frame (CLK_DIV=2,
// FRAME_GAP=16). A sclk-rising-edge decoder rebuilds header bytes and pixel
// words; a two-register renderer stub returns {3'b0, pixel_index}.
module tb_oled_pixel_streamer;

  localparam int W      = 12;
  localparam int H      = 6;
  localparam int NPIX   = W * H;
  localparam int NBITS  = 48 + 16 * NPIX;
  localparam int TMO    = 20000;

  logic        clk25 = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [12:0] pixel_index;
  logic [15:0] pixel_data;
  logic        frame_begin, busy, cs_n, sclk, sdin, dc;

  int n_checks = 0;
  int n_errors = 0;

  // Header for a 12x6 window: 0x15,0x00,0x0B,0x75,0x00,0x05.
  logic [7:0] hdr_exp [6] = '{8'h15, 8'h00, 8'h0B, 8'h75, 8'h00, 8'h05};

  logic mon_bits [$];
  logic mon_dc   [$];
  int   cyc = 0, last_rise = 0, bad_per = 0, cs_glitch = 0, fb_total = 0;
  bit   have_last = 1'b0;
  logic sclk_prev = 1'b1;
  logic [15:0] dec_words [NPIX];

  oled_pixel_streamer #(.WIDTH(W), .HEIGHT(H), .CLK_DIV(2), .FRAME_GAP(16)) dut (
    .clk25(clk25), .rst_n(rst_n), .enable(enable), .pixel_index(pixel_index),
    .pixel_data(pixel_data), .frame_begin(frame_begin), .busy(busy),
    .cs_n(cs_n), .sclk(sclk), .sdin(sdin), .dc(dc)
  );

  always #5 clk25 = ~clk25;

  // Renderer stub with two register stages of latency.
  logic [12:0] r1 = '0, r2 = '0;
  always_ff @(posedge clk25) begin
    r1 <= pixel_index;
    r2 <= r1;
  end
`ifdef STREAMER_TEST_PATTERN_EN
  assign pixel_data = 16'h1234;
`else
  assign pixel_data = {3'b000, r2};
`endif

  // Panel-side decoder and timing monitor, sampled on the falling clk25 edge.
  always @(negedge clk25) begin
    cyc++;
    if (frame_begin) begin
      mon_bits.delete();
      mon_dc.delete();
      bad_per   = 0;
      cs_glitch = 0;
      have_last = 1'b0;
      fb_total++;
    end
    if (busy && cs_n) cs_glitch++;
    if (cs_n) begin
      have_last = 1'b0;
    end else if (sclk && !sclk_prev) begin
      mon_bits.push_back(sdin);
      mon_dc.push_back(dc);
      if (have_last && (cyc - last_rise) != 4) bad_per++;
      last_rise = cyc;
      have_last = 1'b1;
    end
    sclk_prev = sclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int p);
`ifdef STREAMER_TEST_PATTERN_EN
    int x, y;
    x = p % W;
    y = p / W;
    return (x == 0 || x == W - 1 || y == 0 || y == H - 1) ? 16'hFFFF : 16'h0000;
`else
    return 16'(p);
`endif
  endfunction

  task automatic wait_fb(input string tag);
    int t = 0;
    while (frame_begin !== 1'b1 && t < TMO) begin
      @(negedge clk25);
      t++;
    end
    check({tag, "_fb_seen"}, 32'(frame_begin), 32'd1);
  endtask

  // Called on the frame_begin cycle: start-of-frame levels and pulse width.
  task automatic fb_checks(input string tag);
    check({tag, "_fb_csn"},  32'(cs_n), 32'd0);
    check({tag, "_fb_busy"}, 32'(busy), 32'd1);
    check({tag, "_fb_sclk"}, 32'(sclk), 32'd0);
    @(negedge clk25);
    check({tag, "_fb_pulse"}, 32'(frame_begin), 32'd0);
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    @(negedge clk25);
    while (busy !== 1'b0 && t < TMO) begin
      @(negedge clk25);
      t++;
    end
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
    check({tag, "_done_csn"},  32'(cs_n), 32'd1);
    check({tag, "_done_sclk"}, 32'(sclk), 32'd1);
    check({tag, "_done_dc"},   32'(dc),   32'd0);
  endtask

  task automatic wait_idx(input string tag, input int target);
    int t = 0;
    while (pixel_index !== 13'(target) && t < TMO) begin
      @(negedge clk25);
      t++;
    end
    check({tag, "_idx_reached"}, 32'(pixel_index), 32'(target));
  endtask

  task automatic analyze_frame(input string tag);
    int nb, nerr, dcerr, base;
    logic [7:0]  b8;
    logic [15:0] w;
    nb = mon_bits.size();
    check({tag, "_bitcount"}, 32'(nb), 32'(NBITS));
    if (nb >= NBITS) begin
      dcerr = 0;
      for (int i = 0; i < 6; i++) begin
        b8 = '0;
        for (int k = 0; k < 8; k++) begin
          b8 = {b8[6:0], mon_bits[8*i+k]};
          if (mon_dc[8*i+k] !== 1'b0) dcerr++;
        end
        check($sformatf("%s_hdr%0d", tag, i), 32'(b8), 32'(hdr_exp[i]));
      end
      nerr = 0;
      for (int p = 0; p < NPIX; p++) begin
        w = '0;
        base = 48 + 16 * p;
        for (int k = 0; k < 16; k++) begin
          w = {w[14:0], mon_bits[base+k]};
          if (mon_dc[base+k] !== 1'b1) dcerr++;
        end
        dec_words[p] = w;
        if (w !== exp_word(p)) nerr++;
      end
      check({tag, "_dc_bad"},    32'(dcerr), 32'd0);
      check({tag, "_pix_first"}, 32'(dec_words[0]), 32'(exp_word(0)));
      check({tag, "_pix_mid"},   32'(dec_words[42]), 32'(exp_word(42)));
      check({tag, "_pix_last"},  32'(dec_words[NPIX-1]), 32'(exp_word(NPIX-1)));
      check({tag, "_pix_bad"},   32'(nerr), 32'd0);
    end
    check({tag, "_sclk_period_bad"}, 32'(bad_per), 32'd0);
    check({tag, "_csn_glitch"},      32'(cs_glitch), 32'd0);
    check({tag, "_idx_wrapped"},     32'(pixel_index), 32'd0);
  endtask

  initial begin
    int gap, fb_before;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk25);
    check("rst_csn",  32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_sdin", 32'(sdin), 32'd0);
    check("rst_dc",   32'(dc),   32'd0);
    check("rst_idx",  32'(pixel_index), 32'd0);
    check("rst_fb",   32'(frame_begin), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Frame 1: header, full pixel stream, continuous sclk.
    rst_n  = 1'b1;
    enable = 1'b1;
    wait_fb("f1");
    fb_checks("f1");
    wait_done("f1");
    analyze_frame("f1");

    // Back-to-back: FRAME_GAP+1 cycles with cs_n high before the next frame.
    gap = 0;
    while (frame_begin !== 1'b1 && gap < TMO) begin
      if (cs_n === 1'b1) gap++;
      @(negedge clk25);
    end
    check("gap_cycles", 32'(gap), 32'd17);

    // Frame 2: enable dropped while pixel 10 shifts; frame must still complete.
    fb_checks("f2");
    wait_idx("f2", 11);
    enable = 1'b0;
    wait_done("f2");
    analyze_frame("f2");
    fb_before = fb_total;
    repeat (200) @(negedge clk25);
    check("idle_no_new_frame", 32'(fb_total), 32'(fb_before));
    check("idle_csn",  32'(cs_n), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Frame 3: asynchronous reset while pixel 40 is shifting.
    enable = 1'b1;
    wait_fb("f3");
    fb_checks("f3");
    wait_idx("f3", 41);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_csn",  32'(cs_n), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_idx",  32'(pixel_index), 32'd0);
    @(negedge clk25);
    rst_n = 1'b1;

    // Frame 4: clean restart after reset.
    wait_fb("f4");
    fb_checks("f4");
    enable = 1'b0;
    wait_done("f4");
    analyze_frame("f4");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
